// File: rtl/div_seq_param_if.sv
// Operand request / result response bundle for div_seq_param.
// The master side issues operands and takes results; the slave side is the divider.
interface div_seq_param_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             signed_mode;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output in_valid, signed_mode, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );

    modport slave (
        input  in_valid, signed_mode, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
    );
endinterface

// File: rtl/div_seq_param.sv
// Sequential restoring divider, signed/unsigned, BITS_PER_CYCLE quotient bits per clock.
// Produces quotient and remainder with divide-by-zero and signed-overflow flags.

module div_seq_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] a_nxt,
    output logic [WIDTH-1:0] q_nxt
);
    // The shifted partial remainder keeps its carry-out bit, so a divisor with
    // its MSB set still compares correctly; the MSB is never treated as a sign.
    logic [WIDTH:0] sh;
    logic           ge;

    assign sh    = {a, q[WIDTH-1]};
    assign ge    = (sh >= {1'b0, d});
    assign a_nxt = ge ? (sh[WIDTH-1:0] - d) : sh[WIDTH-1:0];
    assign q_nxt = {q[WIDTH-2:0], ge};
endmodule

module div_seq_param #(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input logic            clk,
    input logic            rst_n,
    div_seq_param_if.slave bus
);
    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0] a_r, q_r, d_r, dvd_r;
    logic [CW-1:0]    cnt;
    logic             neg_q, neg_r, dbz_r, ovf_r;

    logic [WIDTH-1:0] quo_o, rem_o;
    logic             dbz_o, ovf_o, vld_o, rdy_o;

    logic accept, calc_en, fix_en, take;

    // Operand decode while IDLE: magnitudes, signs and the two special cases.
    logic             dvd_neg, dvs_neg, in_dbz, in_ovf;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;

    assign dvd_neg = bus.signed_mode & bus.dividend[WIDTH-1];
    assign dvs_neg = bus.signed_mode & bus.divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? -bus.dividend : bus.dividend;
    assign dvs_mag = dvs_neg ? -bus.divisor  : bus.divisor;
    assign in_dbz  = (bus.divisor == '0);
    assign in_ovf  = bus.signed_mode && (bus.dividend == SMIN) && (bus.divisor == '1);

    // Chain of restore steps evaluated within one CALC cycle.
    logic [BITS_PER_CYCLE:0][WIDTH-1:0] a_ch, q_ch;

    assign a_ch[0] = a_r;
    assign q_ch[0] = q_r;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        div_seq_step #(.WIDTH(WIDTH)) u_step (
            .a     (a_ch[g]),
            .q     (q_ch[g]),
            .d     (d_r),
            .a_nxt (a_ch[g+1]),
            .q_nxt (q_ch[g+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.in_valid) state_nxt = (in_dbz || in_ovf) ? FIX : CALC;
            CALC:    if (cnt == CW'(1)) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rdy_o   = 1'b0;
        accept  = 1'b0;
        calc_en = 1'b0;
        fix_en  = 1'b0;
        take    = 1'b0;
        unique case (state)
            IDLE: begin
                rdy_o  = 1'b1;
                accept = bus.in_valid;
            end
            CALC:    calc_en = 1'b1;
            FIX:     fix_en  = 1'b1;
            DONE:    take    = bus.out_ready;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            q_r   <= '0;
            d_r   <= '0;
            dvd_r <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dbz_r <= 1'b0;
            ovf_r <= 1'b0;
        end else if (accept) begin
            a_r   <= '0;
            q_r   <= dvd_mag;
            d_r   <= dvs_mag;
            dvd_r <= bus.dividend;
            cnt   <= CW'(N);
            neg_q <= dvd_neg ^ dvs_neg;
            neg_r <= dvd_neg;
            dbz_r <= in_dbz;
            ovf_r <= in_ovf;
        end else if (calc_en) begin
            a_r <= a_ch[BITS_PER_CYCLE];
            q_r <= q_ch[BITS_PER_CYCLE];
            cnt <= cnt - CW'(1);
        end
    end

    // Result registers only change in FIX, so they hold after the transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_o <= '0;
            rem_o <= '0;
            dbz_o <= 1'b0;
            ovf_o <= 1'b0;
        end else if (fix_en) begin
            if (dbz_r) begin
                quo_o <= '1;
                rem_o <= dvd_r;
                dbz_o <= 1'b1;
                ovf_o <= 1'b0;
            end else if (ovf_r) begin
                quo_o <= dvd_r;
                rem_o <= '0;
                dbz_o <= 1'b0;
                ovf_o <= 1'b1;
            end else begin
                quo_o <= neg_q ? -q_r : q_r;
                rem_o <= neg_r ? -a_r : a_r;
                dbz_o <= 1'b0;
                ovf_o <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      vld_o <= 1'b0;
        else if (fix_en) vld_o <= 1'b1;
        else if (take)   vld_o <= 1'b0;
    end

    assign bus.in_ready    = rdy_o;
    assign bus.out_valid   = vld_o;
    assign bus.quotient    = quo_o;
    assign bus.remainder   = rem_o;
    assign bus.div_by_zero = dbz_o;
    assign bus.overflow    = ovf_o;
endmodule

// File: tb/tb_div_seq_param.sv
// Bench for div_seq_param: directed and random divisions on a 1-bit/cycle and a
// 4-bit/cycle instance, compared with a plain-arithmetic reference.
module tb_div_seq_param;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    div_seq_param_if #(.WIDTH(W)) b1 ();
    div_seq_param_if #(.WIDTH(W)) b4 ();

    div_seq_param #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    div_seq_param #(.WIDTH(W), .BITS_PER_CYCLE(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: straight integer arithmetic (SV division truncates toward zero).
    function automatic void model(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz, output logic ov);
        int sa, sb;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 0) begin
            q = '1; r = a; dz = 1'b1;
        end else if (sm && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = '0; ov = 1'b1;
        end else if (sm) begin
            sa = a; sb = b;
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic logic ov_of(input bit s);  return s ? b4.out_valid   : b1.out_valid;   endfunction
    function automatic logic ir_of(input bit s);  return s ? b4.in_ready    : b1.in_ready;    endfunction
    function automatic logic dz_of(input bit s);  return s ? b4.div_by_zero : b1.div_by_zero; endfunction
    function automatic logic of_of(input bit s);  return s ? b4.overflow    : b1.overflow;    endfunction
    function automatic logic [W-1:0] q_of(input bit s); return s ? b4.quotient  : b1.quotient;  endfunction
    function automatic logic [W-1:0] r_of(input bit s); return s ? b4.remainder : b1.remainder; endfunction

    task automatic drive(input bit s, input logic v, input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
        if (s) begin
            b4.in_valid = v; b4.signed_mode = sm; b4.dividend = a; b4.divisor = b;
        end else begin
            b1.in_valid = v; b1.signed_mode = sm; b1.dividend = a; b1.divisor = b;
        end
    endtask

    task automatic set_ordy(input bit s, input logic v);
        if (s) b4.out_ready = v;
        else   b1.out_ready = v;
    endtask

    task automatic run(input string tag, input bit s, input logic sm,
                       input logic [W-1:0] a, input logic [W-1:0] b, input bit early_rdy);
        logic [W-1:0] eq, er;
        logic         edz, eov;
        int           cyc, n;
        model(sm, a, b, eq, er, edz, eov);
        n = s ? W / 4 : W;
        @(negedge clk);
        chk({tag, ".in_ready"}, ir_of(s), 1'b1);
        drive(s, 1'b1, sm, a, b);
        set_ordy(s, early_rdy);
        @(posedge clk); #1;
        drive(s, 1'b0, sm, a, b);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!ov_of(s) && cyc < 200);
        chk({tag, ".latency"}, cyc + 1, (edz || eov) ? 2 : n + 2);
        chk({tag, ".quotient"}, q_of(s), eq);
        chk({tag, ".remainder"}, r_of(s), er);
        chk({tag, ".div_by_zero"}, dz_of(s), edz);
        chk({tag, ".overflow"}, of_of(s), eov);
        if (early_rdy) begin
            @(posedge clk); #1;
            chk({tag, ".one_cycle"}, ov_of(s), 1'b0);
            set_ordy(s, 1'b0);
        end else begin
            @(negedge clk);
            set_ordy(s, 1'b1);
            @(posedge clk); #1;
            set_ordy(s, 1'b0);
            chk({tag, ".taken"}, ov_of(s), 1'b0);
        end
        chk({tag, ".idle"}, ir_of(s), 1'b1);
    endtask

    initial begin
        int          cyc;
        bit          seen;
        logic [W-1:0] ra, rb;

        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        set_ordy(0, 1'b0);
        set_ordy(1, 1'b0);
        #1;
        for (int s = 0; s < 2; s++) begin
            chk("reset.in_ready", ir_of(s[0]), 1'b1);
            chk("reset.out_valid", ov_of(s[0]), 1'b0);
            chk("reset.quotient", q_of(s[0]), '0);
            chk("reset.remainder", r_of(s[0]), '0);
            chk("reset.flags", {dz_of(s[0]), of_of(s[0])}, 2'b00);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run("u100_7", 0, 1'b0, 100, 7, 1'b0);
        run("u100_7.bpc4", 1, 1'b0, 100, 7, 1'b0);
        run("big_div", 0, 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
        run("big_div.bpc4", 1, 1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
        run("big_div2", 0, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        run("s_m7_2", 0, 1'b1, -32'sd7, 32'sd2, 1'b0);
        run("s_7_m2", 0, 1'b1, 32'sd7, -32'sd2, 1'b0);
        run("s_m7_m2", 1, 1'b1, -32'sd7, -32'sd2, 1'b0);
        run("dbz", 0, 1'b0, 1234, 0, 1'b0);
        run("dbz.signed", 1, 1'b1, -32'sd5, 0, 1'b0);
        run("ovf", 0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run("ovf.bpc4", 1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run("unsigned_min_m1", 0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run("early_rdy", 0, 1'b0, 1000, 9, 1'b1);
        run("early_rdy.bpc4", 1, 1'b1, -32'sd1000, 9, 1'b1);

        // Result held while out_ready stays low; an in_valid pulse in DONE is dropped.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 100, 7);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 100, 7);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!b1.out_valid && cyc < 200);
        chk("hold.latency", cyc + 1, 34);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(0, (i == 2), 1'b0, 50, 5);
            chk("hold.out_valid", b1.out_valid, 1'b1);
            chk("hold.quotient", b1.quotient, 14);
            chk("hold.remainder", b1.remainder, 2);
            chk("hold.in_ready", b1.in_ready, 1'b0);
        end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 50, 5);
        set_ordy(0, 1'b1);
        @(posedge clk); #1;
        set_ordy(0, 1'b0);
        chk("hold.idle_next", b1.in_ready, 1'b1);
        chk("hold.taken", b1.out_valid, 1'b0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (b1.out_valid) seen = 1'b1;
        end
        chk("hold.dropped_pulse", seen, 1'b0);
        chk("hold.result_kept", b1.quotient, 14);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 1000, 3);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 1000, 3);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset.quotient", b1.quotient, '0);
        chk("midreset.remainder", b1.remainder, '0);
        chk("midreset.out_valid", b1.out_valid, 1'b0);
        chk("midreset.in_ready", b1.in_ready, 1'b1);
        chk("midreset.flags", {b1.div_by_zero, b1.overflow}, 2'b00);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (b1.out_valid) seen = 1'b1;
        end
        chk("midreset.aborted", seen, 1'b0);
        run("after_reset", 0, 1'b0, 100, 7, 1'b0);
        run("after_reset.bpc4", 1, 1'b0, 100, 7, 1'b0);

        // Random operands with a bias toward the edge cases.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0:       ra = 32'h8000_0000;
                1:       ra = $urandom_range(0, 255);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = 32'hFFFF_FFFF;
                2:       rb = $urandom | 32'h8000_0000;
                3:       rb = $urandom_range(1, 15);
                default: rb = $urandom >> $urandom_range(0, 31);
            endcase
            run("random", i[0], $urandom_range(0, 1) == 1, ra, rb, $urandom_range(0, 3) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
